ram_port_arbiter: RTL
=====================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 16, width of the RAM address bus on all ports.
REQ-002 Parameter DATA_BITS, default 8, width of the RAM data bus on all ports.
REQ-003 clk  in  1  system clock; all logic is on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 hold_cpu  in  1  while 1, CPU requests stay pending and are not granted (SPI load mode).
REQ-006 cpu_req  in  1  one-cycle CPU access strobe.
REQ-007 cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req.
REQ-008 cpu_addr  in  ADDR_BITS  CPU address; qualified by cpu_req.
REQ-009 cpu_wdata  in  DATA_BITS  CPU write data; qualified by cpu_req.
REQ-010 cpu_busy  out  1  CPU access pending or in flight; drives the CPU wait_n low.
REQ-011 cpu_ack  out  1  one-cycle completion pulse for the CPU access.
REQ-012 cpu_rdata  out  DATA_BITS  CPU read data; valid when cpu_ack is 1 and held until the next CPU ack.
REQ-013 spi_req, spi_we, spi_addr, spi_wdata  in  1/1/ADDR_BITS/DATA_BITS  SPI-slave access; same rules as the CPU request inputs.
REQ-014 spi_ack, spi_rdata  out  1/DATA_BITS  SPI completion pulse and read data; same rules as the CPU outputs.
REQ-015 overflow  out  1  sticky flag; set when a strobe arrives while that requester already has an access outstanding.
REQ-016 ram_en, ram_we  out  1/1  registered RAM port strobes.
REQ-017 ram_addr, ram_wdata  out  ADDR_BITS/DATA_BITS  registered RAM port address and write data.
REQ-018 ram_rdata  in  DATA_BITS  RAM read data; valid one cycle after the ram_en cycle (synchronous read).

Function
REQ-019 Each requester SHALL have a one-entry pending register that captures we, addr and wdata on its strobe.
REQ-020 A requester is outstanding from its strobe until the cycle its ack is asserted.
REQ-021 A strobe from a requester that is already outstanding SHALL be dropped and SHALL set overflow; the pending entry is unchanged.
REQ-022 The FSM SHALL have three states: IDLE, ISSUE, WAIT.
REQ-023 IDLE: if any eligible request is pending, latch the winner, register the ram_* outputs, and go to ISSUE; otherwise stay in IDLE.
REQ-024 ISSUE: ram_en = 1 and ram_we = winner's we, for exactly this one cycle; next state is WAIT.
REQ-025 WAIT: at the end of the cycle, capture ram_rdata into the winner's rdata (reads only; writes leave rdata unchanged), clear the winner's pending entry, pulse the winner's ack in the next cycle, and go to IDLE.
REQ-026 Uncontended latency: strobe in cycle 0 -> ISSUE in cycle 2 -> ack in cycle 4.
REQ-027 Peak throughput: one access per 3 cycles; IDLE may grant in the same cycle an ack is asserted.
REQ-028 A CPU request is eligible only when hold_cpu = 0; SPI requests are always eligible.
REQ-029 When both requesters are eligible in IDLE, grant round-robin: the requester not granted last wins.
REQ-030 A strobe arriving in the same cycle as that requester's ack SHALL be accepted as a new request, not counted as an overflow.
REQ-031 cpu_busy = CPU outstanding (combinational from registered state).
REQ-032 When not in ISSUE, ram_en = 0 and ram_we = 0; ram_addr and ram_wdata hold their last values.

Reset
REQ-033 On reset: state = IDLE; both pending entries cleared; last-grant pointer = SPI, so the CPU wins the first tie.
REQ-034 On reset, these outputs SHALL be 0: ram_en, ram_we, ram_addr, ram_wdata, cpu_ack, spi_ack, cpu_rdata, spi_rdata, overflow, cpu_busy.
REQ-035 Reset during ISSUE or WAIT SHALL abort the access: no ack is issued, and the RAM write, if already strobed, stands.

Configuration
REQ-036 Macro RAM_PORT_ARB_FIXED_PRIO_EN: when defined, SPI always wins a tie (no round-robin) and the last-grant pointer is not implemented; when undefined, REQ-029 applies.

Verification
REQ-037 CPU read only: preload addr 0x1234 = 0xA5; cpu_req read at cycle 0 -> ram_en cycle 2 with addr 0x1234; cpu_ack cycle 4 with cpu_rdata = 0xA5; cpu_busy high in cycles 1-4.
REQ-038 Simultaneous strobes after reset: CPU write 0x0010 = 0x11 and SPI write 0x0020 = 0x22 -> CPU granted first (ISSUE cycle 2), SPI second (ISSUE cycle 5); acks at cycles 4 and 7; with RAM_PORT_ARB_FIXED_PRIO_EN defined, the order is reversed.
REQ-039 hold_cpu = 1 with a CPU read pending plus 3 SPI writes in sequence -> all SPI writes complete, the CPU is not granted and cpu_busy stays 1; deassert hold_cpu -> CPU ack 3 cycles later.
REQ-040 Second cpu_req at cycle 1 while the first is outstanding -> overflow = 1 and stays 1; only one cpu_ack is issued; a new cpu_req in the ack cycle is accepted and acked.
REQ-041 Reset asserted during WAIT of an SPI read -> no spi_ack; all outputs 0 in the cycle after reset; the CPU wins the next tie.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-requester (CPU, SPI) arbiter onto a single synchronous-read RAM port.
// Define RAM_PORT_ARB_FIXED_PRIO_EN to make SPI win every tie instead of round-robin.
module ram_port_arbiter #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hold_cpu,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [DATA_BITS-1:0] cpu_wdata,
    output logic                 cpu_busy,
    output logic                 cpu_ack,
    output logic [DATA_BITS-1:0] cpu_rdata,
    input  logic                 spi_req,
    input  logic                 spi_we,
    input  logic [ADDR_BITS-1:0] spi_addr,
    input  logic [DATA_BITS-1:0] spi_wdata,
    output logic                 spi_ack,
    output logic [DATA_BITS-1:0] spi_rdata,
    output logic                 overflow,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [DATA_BITS-1:0] ram_wdata,
    input  logic [DATA_BITS-1:0] ram_rdata
);

    localparam int NUM_REQ = 2;   // index 0 = CPU, 1 = SPI

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t state;

    logic [NUM_REQ-1:0]                req;
    logic [NUM_REQ-1:0]                we_in;
    logic [NUM_REQ-1:0][ADDR_BITS-1:0] addr_in;
    logic [NUM_REQ-1:0][DATA_BITS-1:0] wdata_in;

    logic [NUM_REQ-1:0]                pend;
    logic [NUM_REQ-1:0]                pend_we;
    logic [NUM_REQ-1:0][ADDR_BITS-1:0] pend_addr;
    logic [NUM_REQ-1:0][DATA_BITS-1:0] pend_wdata;

    logic [NUM_REQ-1:0]                ack;
    logic [NUM_REQ-1:0][DATA_BITS-1:0] rdata;
    logic [NUM_REQ-1:0]                elig;
    logic [NUM_REQ-1:0]                done_mask;

    logic win;
    logic win_we;
    logic grant_sel;

    assign req      = {spi_req, cpu_req};
    assign we_in    = {spi_we, cpu_we};
    assign addr_in  = {spi_addr, cpu_addr};
    assign wdata_in = {spi_wdata, cpu_wdata};

    assign elig      = {pend[1], pend[0] & ~hold_cpu};
    assign done_mask = (state == WAIT) ? (2'b01 << win) : 2'b00;

`ifdef RAM_PORT_ARB_FIXED_PRIO_EN
    assign grant_sel = elig[1];
`else
    logic last;   // last granted requester; the other one wins a tie
    assign grant_sel = elig[1] & (~elig[0] | ~last);
`endif

    // Pending entries; a strobe while pending is dropped, so capture and clear never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend       <= '0;
            pend_we    <= '0;
            pend_addr  <= '0;
            pend_wdata <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && !pend[i]) begin
                    pend[i]       <= 1'b1;
                    pend_we[i]    <= we_in[i];
                    pend_addr[i]  <= addr_in[i];
                    pend_wdata[i] <= wdata_in[i];
                end else if (done_mask[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            overflow <= 1'b0;
        else if (|(req & pend))
            overflow <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ack       <= '0;
            rdata     <= '0;
            win       <= 1'b0;
            win_we    <= 1'b0;
`ifndef RAM_PORT_ARB_FIXED_PRIO_EN
            last      <= 1'b1;
`endif
        end else begin
            ack    <= '0;
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (|elig) begin
                        win       <= grant_sel;
                        win_we    <= pend_we[grant_sel];
                        ram_en    <= 1'b1;
                        ram_we    <= pend_we[grant_sel];
                        ram_addr  <= pend_addr[grant_sel];
                        ram_wdata <= pend_wdata[grant_sel];
`ifndef RAM_PORT_ARB_FIXED_PRIO_EN
                        last      <= grant_sel;
`endif
                        state     <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    // RAM output now reflects the ISSUE-cycle read
                    if (!win_we)
                        rdata[win] <= ram_rdata;
                    ack[win] <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cpu_ack   = ack[0];
    assign spi_ack   = ack[1];
    assign cpu_rdata = rdata[0];
    assign spi_rdata = rdata[1];
    assign cpu_busy  = pend[0] | ack[0];

endmodule
